// File: rtl/dvfs_transition_sequencer.sv
// DVFS P-state transition sequencer: orders voltage and frequency updates so the
// applied voltage always covers the applied frequency. Optional macro DVFS_SEQ_VSTEP_EN
// ramps the voltage one code per step instead of jumping directly.
module dvfs_transition_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned STEP_CYCLES   = 100,
  parameter int unsigned RESET_PSTATE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_pstate,
  output logic       req_ready,
  output logic [1:0] cur_pstate,
  output logic [2:0] voltage_code,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 32;

`ifdef DVFS_SEQ_VSTEP_EN
  localparam bit VSTEP_EN = 1'b1;
`else
  localparam bit VSTEP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES);
  localparam logic [1:0]       RST_PS      = 2'(RESET_PSTATE);

  typedef enum logic [2:0] {
    IDLE, UP_V, UP_WAIT, UP_F, DN_F, DN_WAIT, DN_V, NOP
  } state_t;

  // Fixed voltage code per P-state
  function automatic logic [2:0] vt(input logic [1:0] p);
    case (p)
      2'd0:    vt = 3'd7;
      2'd1:    vt = 3'd5;
      2'd2:    vt = 3'd3;
      default: vt = 3'd1;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [1:0]       cur_q, cur_d;
  logic [2:0]       volt_q, volt_d;
  logic             done_q, done_d;
  logic             busy_q, ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    volt_d  = volt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d = req_pstate;
          cnt_d = '0;
          if (req_pstate < cur_q)      state_d = UP_V;
          else if (req_pstate > cur_q) state_d = DN_F;
          else                         state_d = NOP;
        end
      end
      UP_V: begin
        // In step mode cnt_q holds the inter-step wait; it is zero on entry
        if (VSTEP_EN && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          volt_d = VSTEP_EN ? 3'(volt_q + 3'd1) : vt(tgt_q);
          if (VSTEP_EN && volt_d != vt(tgt_q)) begin
            cnt_d = STEP_LOAD;
          end else if (SETTLE_CYCLES == 0) begin
            state_d = UP_F;
          end else begin
            state_d = UP_WAIT;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      UP_WAIT: begin
        if (cnt_q == '0) state_d = UP_F;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      UP_F: begin
        cur_d   = tgt_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DN_F: begin
        cur_d = tgt_q;
        if (SETTLE_CYCLES == 0) begin
          state_d = DN_V;
        end else begin
          state_d = DN_WAIT;
          cnt_d   = SETTLE_LOAD;
        end
      end
      DN_WAIT: begin
        if (cnt_q == '0) state_d = DN_V;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DN_V: begin
        if (VSTEP_EN && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          volt_d = VSTEP_EN ? 3'(volt_q - 3'd1) : vt(tgt_q);
          if (VSTEP_EN && volt_d != vt(tgt_q)) begin
            cnt_d = STEP_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      NOP: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= RST_PS;
      cur_q   <= RST_PS;
      volt_q  <= vt(RST_PS);
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      volt_q  <= volt_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      ready_q <= (state_d == IDLE);
    end
  end

  assign req_ready    = ready_q;
  assign cur_pstate   = cur_q;
  assign voltage_code = volt_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
